// File: rtl/ifu_pkg.sv
// Shared IFU types and constants.
// Predecode slot layout and a slot popcount helper.
package ifu_pkg;

  localparam int PD_SLOTS = 16;
  localparam int PD_OFS_W = 64;
  localparam int PD_CNT_W = 5;

  typedef struct packed {
    logic                valid;
    logic                isRVC;
    logic [31:0]         instr;
    logic [PD_OFS_W-1:0] jump_offset;
  } pd_slot_t;

  function automatic logic [PD_CNT_W-1:0] popcount(
    input logic [PD_SLOTS-1:0] v
  );
    logic [PD_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < PD_SLOTS; i++)
      c = c + PD_CNT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/ifu_pd_slot_mask.sv
// Effective slot-valid mask for one fetch block.
// Trims past last_idx, hides a straddle tail in slot 0.
module ifu_pd_slot_mask
  import ifu_pkg::*;
#(
  parameter int SLOTS = PD_SLOTS,
  parameter int IDX_W = $clog2(SLOTS),
  parameter int CNT_W = PD_CNT_W
) (
  input  logic [IDX_W-1:0] last_idx,
  input  logic             half_pend,
  input  logic [SLOTS-1:0] pd_valid,
  input  logic [SLOTS-1:0] pd_isRVC,
  output logic [SLOTS-1:0] eff,
  output logic [CNT_W-1:0] cnt,
  output logic             half_next
);

  // Per-slot range trim, then slot-0 tail mask.
  always_comb begin
    eff = '0;
    for (int i = 0; i < SLOTS; i++)
      eff[i] = pd_valid[i] && (IDX_W'(i) <= last_idx);
    if (half_pend)
      eff[0] = 1'b0;
  end

  assign cnt = CNT_W'(popcount(PD_SLOTS'(eff)));

  // A masked last slot can never open a new straddle.
  assign half_next = eff[last_idx] && !pd_isRVC[last_idx];

endmodule

// File: rtl/ifu_f3_pd_stage.sv
// F3 predecode stage register towards the instruction buffer.
// Single-entry valid/ready slice plus straddle tracking.
module ifu_f3_pd_stage
  import ifu_pkg::*;
#(
  parameter int SLOTS = PD_SLOTS,
  parameter int OFS_W = PD_OFS_W,
  parameter int CNT_W = PD_CNT_W,
  localparam int IDX_W = $clog2(SLOTS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IDX_W-1:0]       in_last_idx,
  input  logic [SLOTS-1:0]       in_pd_valid,
  input  logic [SLOTS-1:0]       in_pd_isRVC,
  input  logic [SLOTS*32-1:0]    in_instr,
  input  logic [SLOTS*OFS_W-1:0] in_jump_offset,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SLOTS-1:0]       out_pd_valid,
  output logic [SLOTS-1:0]       out_pd_isRVC,
  output logic [SLOTS*32-1:0]    out_instr,
  output logic [SLOTS*OFS_W-1:0] out_jump_offset,
  output logic [CNT_W-1:0]       out_inst_cnt,
  output logic                   out_tail_masked,
  output logic                   out_ends_half
);

  logic             half_pend;
  logic             accept;
  logic [SLOTS-1:0] eff;
  logic [CNT_W-1:0] cnt;
  logic             half_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  ifu_pd_slot_mask #(
    .SLOTS (SLOTS),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_mask (
    .last_idx  (in_last_idx),
    .half_pend (half_pend),
    .pd_valid  (in_pd_valid),
    .pd_isRVC  (in_pd_isRVC),
    .eff       (eff),
    .cnt       (cnt),
    .half_next (half_next)
  );

  // Stage register; flush wins over a same-cycle accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid       <= 1'b0;
      half_pend       <= 1'b0;
      out_pd_valid    <= '0;
      out_pd_isRVC    <= '0;
      out_instr       <= '0;
      out_jump_offset <= '0;
      out_inst_cnt    <= '0;
      out_tail_masked <= 1'b0;
      out_ends_half   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      half_pend <= 1'b0;
    end else if (accept) begin
      out_valid       <= 1'b1;
      half_pend       <= half_next;
      out_pd_valid    <= eff;
      out_pd_isRVC    <= in_pd_isRVC;
      out_instr       <= in_instr;
      out_jump_offset <= in_jump_offset;
      out_inst_cnt    <= cnt;
      out_tail_masked <= half_pend;
      out_ends_half   <= half_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifu_f3_pd_stage.sv
// Scoreboard bench for ifu_f3_pd_stage.
// Directed blocks, expectations queued on accept.
module tb_ifu_f3_pd_stage;

  localparam int S = 16;
  localparam int W = 64;

  typedef struct {
    logic [S-1:0]    pd;
    logic [S-1:0]    rvc;
    logic [4:0]      cnt;
    logic            tail;
    logic            ends;
    logic [S*32-1:0] instr;
    logic [S*W-1:0]  ofs;
  } exp_t;

  logic             clk = 0;
  logic             rst_n = 0;
  logic             flush = 0;
  logic             in_valid = 0;
  logic             in_ready;
  logic [3:0]       in_last_idx = '0;
  logic [S-1:0]     in_pd_valid = '0;
  logic [S-1:0]     in_pd_isRVC = '0;
  logic [S*32-1:0]  in_instr = '0;
  logic [S*W-1:0]   in_jump_offset = '0;
  logic             out_valid;
  logic             out_ready = 1;
  logic [S-1:0]     out_pd_valid;
  logic [S-1:0]     out_pd_isRVC;
  logic [S*32-1:0]  out_instr;
  logic [S*W-1:0]   out_jump_offset;
  logic [4:0]       out_inst_cnt;
  logic             out_tail_masked;
  logic             out_ends_half;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ifu_f3_pd_stage dut (
    .clock           (clk),
    .reset           (rst_n),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_last_idx     (in_last_idx),
    .in_pd_valid     (in_pd_valid),
    .in_pd_isRVC     (in_pd_isRVC),
    .in_instr        (in_instr),
    .in_jump_offset  (in_jump_offset),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pd_valid    (out_pd_valid),
    .out_pd_isRVC    (out_pd_isRVC),
    .out_instr       (out_instr),
    .out_jump_offset (out_jump_offset),
    .out_inst_cnt    (out_inst_cnt),
    .out_tail_masked (out_tail_masked),
    .out_ends_half   (out_ends_half)
  );

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %0h exp %0h", n, a, e);
    end
  endtask

  function automatic logic [S*32-1:0] mk_instr(int tag);
    logic [S*32-1:0] v;
    for (int i = 0; i < S; i++)
      v[32*i +: 32] = {16'(tag), 8'(i), 8'hA5};
    return v;
  endfunction

  function automatic logic [S*W-1:0] mk_ofs(int tag);
    logic [S*W-1:0] v;
    for (int i = 0; i < S; i++)
      v[W*i +: W] = {32'(tag), 32'(i * 2)};
    return v;
  endfunction

  // Monitor: compare on every output transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_block", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("pd_valid", 64'(out_pd_valid), 64'(e.pd));
          chk("isRVC", 64'(out_pd_isRVC), 64'(e.rvc));
          chk("inst_cnt", 64'(out_inst_cnt), 64'(e.cnt));
          chk("tail_masked", 64'(out_tail_masked), 64'(e.tail));
          chk("ends_half", 64'(out_ends_half), 64'(e.ends));
          chk("instr", 64'(out_instr == e.instr), 1);
          chk("jump_offset", 64'(out_jump_offset == e.ofs), 1);
        end
      end
    end
  end

  task automatic drive(int tag, logic [3:0] li, logic [S-1:0] pd,
                       logic [S-1:0] rvc);
    in_last_idx    = li;
    in_pd_valid    = pd;
    in_pd_isRVC    = rvc;
    in_instr       = mk_instr(tag);
    in_jump_offset = mk_ofs(tag);
    in_valid       = 1;
  endtask

  // Send one block; queue expectation unless flushed.
  task automatic send(int tag, logic [3:0] li, logic [S-1:0] pd,
                      logic [S-1:0] rvc, logic [S-1:0] epd,
                      logic [4:0] ecnt, logic et, logic ee,
                      logic fl);
    exp_t e;
    bit done = 0;
    drive(tag, li, pd, rvc);
    flush = fl;
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      if (in_ready) begin
        done = 1;
        if (!fl) begin
          e.pd = epd; e.rvc = rvc; e.cnt = ecnt;
          e.tail = et; e.ends = ee;
          e.instr = mk_instr(tag); e.ofs = mk_ofs(tag);
          sb.push_back(e);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (!done) chk("accept_timeout", 0, 1);
    in_valid = 0;
    flush = 0;
  endtask

  initial begin
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_pd_valid", 64'(out_pd_valid), 0);
    chk("rst_cnt", 64'(out_inst_cnt), 0);
    chk("rst_tail", 64'(out_tail_masked), 0);
    chk("rst_ends", 64'(out_ends_half), 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 1);
    @(negedge clk);

    send(1, 15, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16, 0, 0, 0);
    send(2, 7, 16'h00D5, 16'hFF7F, 16'h00D5, 5, 0, 1, 0);
    send(3, 15, 16'h0005, 16'hFFFF, 16'h0004, 1, 1, 0, 0);

    @(negedge clk);
    out_ready = 0;
    send(4, 15, 16'h0003, 16'hFFFF, 16'h0003, 2, 0, 0, 0);
    drive(5, 15, 16'h8001, 16'h7FFF);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_in_ready", 64'(in_ready), 0);
      chk("stall_valid", 64'(out_valid), 1);
      chk("stall_pd", 64'(out_pd_valid), 64'h0003);
      chk("stall_instr", 64'(out_instr == mk_instr(4)), 1);
      @(negedge clk);
    end
    out_ready = 1;
    send(5, 15, 16'h8001, 16'h7FFF, 16'h8001, 2, 0, 1, 0);

    send(6, 0, 16'h0001, 16'hFFFF, 16'h0000, 0, 1, 0, 0);
    send(7, 4, 16'h0011, 16'hFFEF, 16'h0011, 2, 0, 1, 0);

    send(8, 15, 16'hFFFF, 16'hFFFF, 16'h0, 0, 0, 0, 1);
    #1;
    chk("flush_out_valid", 64'(out_valid), 0);
    send(9, 1, 16'h0003, 16'hFFFF, 16'h0003, 2, 0, 0, 0);

    @(negedge clk);
    out_ready = 0;
    send(10, 15, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16, 0, 0, 0);
    #2;
    chk("pre_rst_valid", 64'(out_valid), 1);
    rst_n = 0;
    #1;
    chk("arst_valid", 64'(out_valid), 0);
    chk("arst_pd", 64'(out_pd_valid), 0);
    chk("arst_cnt", 64'(out_inst_cnt), 0);
    chk("arst_ends", 64'(out_ends_half), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    #1;
    chk("arst_in_ready", 64'(in_ready), 1);
    @(negedge clk);
    send(11, 15, 16'h0101, 16'hFFFF, 16'h0101, 2, 0, 0, 0);

    for (int k = 0; k < 50 && sb.size() != 0; k++)
      @(negedge clk);
    #3;
    chk("sb_drained", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
